// File: rtl/dispatch_fifo_rr_scheduler.sv
// Round-robin burst drain scheduler for show-ahead dispatcher FIFOs.
// One queue is granted at a time; popped words pass through a one-entry registered output stage.
module dispatch_fifo_rr_scheduler #(
  parameter int NUM_Q      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4,
  localparam int QID_W     = $clog2(NUM_Q),
  localparam int BEAT_W    = $clog2(MAX_BURST) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [NUM_Q-1:0]            q_empty,
  input  logic [NUM_Q*DATA_WIDTH-1:0] q_data,
  output logic [NUM_Q-1:0]            q_pop,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [QID_W-1:0]            out_qid,
  input  logic                        out_ready,
  output logic                        busy
);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t                state_q, state_d;
  logic [QID_W-1:0]      cur_q_q, cur_q_d;
  logic [QID_W-1:0]      last_grant_q, last_grant_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [QID_W-1:0]      out_qid_q, out_qid_d;

  logic [DATA_WIDTH-1:0] head [NUM_Q];
  logic [QID_W-1:0]      next_q;
  logic [QID_W-1:0]      cand;
  logic                  found;
  logic                  any_req;
  logic                  slot_free;
  logic                  pop;
  logic                  burst_last;

  always_comb begin
    for (int i = 0; i < NUM_Q; i++) begin
      head[i] = q_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Rotating priority: first non-empty queue strictly after the last grant.
  always_comb begin
    next_q = last_grant_q;
    cand   = last_grant_q;
    found  = 1'b0;
    for (int i = 1; i <= NUM_Q; i++) begin
      cand = QID_W'((int'(last_grant_q) + i) % NUM_Q);
      if (!found && !q_empty[cand]) begin
        next_q = cand;
        found  = 1'b1;
      end
    end
  end

  // Output handshake: a word transfers on any cycle where out_valid && out_ready;
  // out_data/out_qid are held stable while out_valid && !out_ready.
  assign any_req    = ~&q_empty;
  assign slot_free  = !out_valid_q || out_ready;
  assign pop        = (state_q == ST_BURST) && enable && !q_empty[cur_q_q] && slot_free;
  assign burst_last = (beat_cnt_q == BEAT_W'(MAX_BURST - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cur_q_q      <= '0;
      last_grant_q <= QID_W'(NUM_Q - 1);
      beat_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_qid_q    <= '0;
    end else begin
      state_q      <= state_d;
      cur_q_q      <= cur_q_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_qid_q    <= out_qid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_q_d      = cur_q_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && any_req) begin
          cur_q_d    = next_q;
          beat_cnt_d = '0;
          state_d    = ST_BURST;
        end
      end
      ST_BURST: begin
        if (pop) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        end
        // Backpressure alone keeps the grant; only completion, drain or disable end it.
        if ((pop && burst_last) || q_empty[cur_q_q] || !enable) begin
          state_d      = ST_IDLE;
          last_grant_d = cur_q_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    q_pop       = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_qid_d   = out_qid_q;
    if (pop) begin
      q_pop[cur_q_q] = 1'b1;
      out_valid_d    = 1'b1;
      out_data_d     = head[cur_q_q];
      out_qid_d      = cur_q_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_qid   = out_qid_q;
  assign busy      = (state_q == ST_BURST) || out_valid_q;

endmodule
